key_repeat_controller: RTL and testbench

KEY_REPEAT_CONTROLLER -- requirements
Module: key_repeat_controller

---
 rtl/key_repeat_pkg.sv | 15 +
 rtl/repeat_timer.sv | 27 ++
 rtl/key_repeat_controller.sv | 118 +++++++++++
 tb/tb_key_repeat_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_repeat_pkg.sv
// Shared FSM encoding and interval defaults for the key auto-repeat controller.
package key_repeat_pkg;

   localparam int TIMER_W = 28;

   localparam logic [TIMER_W-1:0] DEFAULT_DELAY_CYCLES  = 28'd50_000_000;
   localparam logic [TIMER_W-1:0] DEFAULT_REPEAT_CYCLES = 28'd10_000_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/repeat_timer.sv
// Loadable down-counter pacing the gap between key events.
module repeat_timer
   import key_repeat_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               load,
   input  logic               en,
   output logic [TIMER_W-1:0] count,
   output logic               zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - TIMER_W'(1);
      end
   end

   // High in the cycle whose decrement lands on zero, so the owner acts on that same edge.
   assign zero = (count <= TIMER_W'(1));

endmodule

// File: rtl/key_repeat_controller.sv
// Turns a held key into one initial press event followed by paced auto-repeat events.
module key_repeat_controller
   import key_repeat_pkg::*;
#(
   parameter logic [TIMER_W-1:0] DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
   parameter logic [TIMER_W-1:0] REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
)(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               KEY_HELD,
   input  logic [7:0]         KEY_CODE,
   output logic               EVENT_VALID,
   input  logic               EVENT_READY,
   output logic [7:0]         EVENT_CODE,
   output logic               EVENT_REPEAT,
   output state_e             DEBUG_STATE,
   output logic [TIMER_W-1:0] DEBUG_TIMER
);

   // Handshake: an event transfers on a rising CLK edge where EVENT_VALID and EVENT_READY are
   // both high; once raised, VALID/CODE/REPEAT hold unchanged until that edge.
   state_e             state;
   state_e             state_next;
   logic [7:0]         code_q;
   logic               repeat_q;
   logic               handshake;
   logic               load_code;
   logic               mark_repeat;
   logic               timer_load;
   logic               timer_en;
   logic [TIMER_W-1:0] timer_load_value;
   logic [TIMER_W-1:0] timer_count;
   logic               timer_zero;

   assign handshake = EVENT_VALID & EVENT_READY;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      load_code        = 1'b0;
      mark_repeat      = 1'b0;
      timer_load       = 1'b0;
      timer_load_value = '0;
      unique case (state)
         ST_IDLE: begin
            if (KEY_HELD) begin
               state_next = ST_EMIT;
               load_code  = 1'b1;
            end
         end
         ST_EMIT: begin
            if (handshake) begin
               if (KEY_HELD) begin
                  state_next       = ST_WAIT;
                  timer_load       = 1'b1;
                  timer_load_value = repeat_q ? (REPEAT_CYCLES - TIMER_W'(1))
                                              : (DELAY_CYCLES - TIMER_W'(1));
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            // A different key wins over timer expiry: it is a new press, not a repeat.
            if (!KEY_HELD) begin
               state_next = ST_IDLE;
            end else if (KEY_CODE != code_q) begin
               state_next = ST_EMIT;
               load_code  = 1'b1;
            end else if (timer_zero) begin
               state_next  = ST_EMIT;
               mark_repeat = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      EVENT_VALID = (state == ST_EMIT);
      timer_en    = (state == ST_WAIT);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         code_q   <= 8'h00;
         repeat_q <= 1'b0;
      end else if (load_code) begin
         code_q   <= KEY_CODE;
         repeat_q <= 1'b0;
      end else if (mark_repeat) begin
         repeat_q <= 1'b1;
      end
   end

   repeat_timer u_timer (
      .clk        (CLK),
      .rst        (RESET),
      .load_value (timer_load_value),
      .load       (timer_load),
      .en         (timer_en),
      .count      (timer_count),
      .zero       (timer_zero)
   );

   assign EVENT_CODE   = code_q;
   assign EVENT_REPEAT = repeat_q;
   assign DEBUG_STATE  = state;
   assign DEBUG_TIMER  = timer_count;

endmodule

// File: tb/tb_key_repeat_controller.sv
// Directed bench for key_repeat_controller with DELAY_CYCLES=8 and REPEAT_CYCLES=3.
module tb_key_repeat_controller;
   import key_repeat_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_held;
   logic [7:0]  key_code;
   logic        event_valid;
   logic        event_ready;
   logic [7:0]  event_code;
   logic        event_repeat;
   state_e      debug_state;
   logic [27:0] debug_timer;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   key_repeat_controller #(
      .DELAY_CYCLES  (28'd8),
      .REPEAT_CYCLES (28'd3)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .KEY_HELD     (key_held),
      .KEY_CODE     (key_code),
      .EVENT_VALID  (event_valid),
      .EVENT_READY  (event_ready),
      .EVENT_CODE   (event_code),
      .EVENT_REPEAT (event_repeat),
      .DEBUG_STATE  (debug_state),
      .DEBUG_TIMER  (debug_timer)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; key_held = 1'b0; key_code = 8'h00; event_ready = 1'b1;
      step(3);
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== 10'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b r=%b c=%h want v=0 r=0 c=00", event_valid, event_repeat, event_code);
      end
      n_cmp++;
      if (debug_state !== ST_IDLE || debug_timer !== 28'd0) begin
         n_bad++;
         $display("FAIL reset_state: got state=%0d timer=%0d want state=0 timer=0", debug_state, debug_timer);
      end
      rst = 1'b0;
      step(2);
      n_cmp++;
      if (event_valid !== 1'b0 || debug_state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL idle_after_reset: got v=%b state=%0d want v=0 state=0", event_valid, debug_state);
      end
   endtask

   task automatic test_repeat();
      logic exp_v;
      logic exp_r;
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b1;
      step(1);
      for (int k = 0; k < 20; k++) begin
         exp_v = (k == 0) || (k == 8) || (k == 11) || (k == 14) || (k == 17);
         exp_r = (k != 0);
         n_cmp++;
         if (event_valid !== exp_v || (exp_v && (event_code !== 8'h41 || event_repeat !== exp_r))) begin
            n_bad++;
            $display("FAIL repeat_k%0d: got v=%b c=%h r=%b want v=%b c=41 r=%b", k, event_valid, event_code, event_repeat, exp_v, exp_r);
         end
         if (k == 1 || k == 9) begin
            n_cmp++;
            if (debug_timer !== ((k == 1) ? 28'd7 : 28'd2)) begin
               n_bad++;
               $display("FAIL repeat_timer_k%0d: got %0d want %0d", k, debug_timer, (k == 1) ? 7 : 2);
            end
         end
         if (k == 19) key_held = 1'b0;
         step(1);
      end
      for (int j = 0; j < 6; j++) begin
         n_cmp++;
         if (event_valid !== 1'b0 || debug_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL after_release_j%0d: got v=%b state=%0d want v=0 state=0", j, event_valid, debug_state);
         end
         step(1);
      end
   endtask

   task automatic test_stall();
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b0;
      step(1);
      for (int j = 0; j < 6; j++) begin
         if (j == 5) event_ready = 1'b1;
         n_cmp++;
         if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h41}) begin
            n_bad++;
            $display("FAIL stall_j%0d: got v=%b r=%b c=%h want v=1 r=0 c=41", j, event_valid, event_repeat, event_code);
         end
         if (j == 1) key_code = 8'h55;
         if (j == 3) key_code = 8'h41;
         step(1);
      end
      for (int k = 1; k <= 8; k++) begin
         n_cmp++;
         if (event_valid !== (k == 8) || (k == 8 && (event_repeat !== 1'b1 || event_code !== 8'h41))) begin
            n_bad++;
            $display("FAIL stall_after_k%0d: got v=%b r=%b c=%h want v=%b r=1 c=41", k, event_valid, event_repeat, event_code, (k == 8));
         end
         if (k == 8) key_held = 1'b0;
         step(1);
      end
      n_cmp++;
      if (debug_state !== ST_IDLE || event_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_end_idle: got state=%0d v=%b want state=0 v=0", debug_state, event_valid);
      end
   endtask

   task automatic test_release();
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b1;
      step(1);
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h41}) begin
         n_bad++;
         $display("FAIL release_first: got v=%b r=%b c=%h want v=1 r=0 c=41", event_valid, event_repeat, event_code);
      end
      step(1);
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (event_valid !== 1'b0 || debug_state !== ST_WAIT) begin
            n_bad++;
            $display("FAIL release_wait_k%0d: got v=%b state=%0d want v=0 state=2", k, event_valid, debug_state);
         end
         if (k == 4) key_held = 1'b0;
         step(1);
      end
      for (int j = 0; j < 10; j++) begin
         n_cmp++;
         if (event_valid !== 1'b0 || debug_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL release_idle_j%0d: got v=%b state=%0d want v=0 state=0", j, event_valid, debug_state);
         end
         step(1);
      end
      key_held = 1'b1;
      step(1);
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h41}) begin
         n_bad++;
         $display("FAIL repress: got v=%b r=%b c=%h want v=1 r=0 c=41", event_valid, event_repeat, event_code);
      end
      key_held = 1'b0;
      step(1);
   endtask

   task automatic test_code_change();
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b1;
      step(2);
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (event_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL change_wait_k%0d: got v=%b want v=0", k, event_valid);
         end
         if (k == 4) key_code = 8'h42;
         step(1);
      end
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h42}) begin
         n_bad++;
         $display("FAIL change_new_press: got v=%b r=%b c=%h want v=1 r=0 c=42", event_valid, event_repeat, event_code);
      end
      step(1);
      for (int m = 1; m <= 8; m++) begin
         n_cmp++;
         if (event_valid !== (m == 8) || (m == 8 && (event_repeat !== 1'b1 || event_code !== 8'h42))) begin
            n_bad++;
            $display("FAIL change_delay_m%0d: got v=%b r=%b c=%h want v=%b r=1 c=42", m, event_valid, event_repeat, event_code, (m == 8));
         end
         if (m == 8) key_held = 1'b0;
         step(1);
      end
   endtask

   task automatic test_change_at_expiry();
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b1;
      step(1);
      step(7);
      n_cmp++;
      if (debug_timer !== 28'd1 || debug_state !== ST_WAIT) begin
         n_bad++;
         $display("FAIL expiry_timer: got timer=%0d state=%0d want timer=1 state=2", debug_timer, debug_state);
      end
      key_code = 8'h43;
      step(1);
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h43}) begin
         n_bad++;
         $display("FAIL expiry_new_press: got v=%b r=%b c=%h want v=1 r=0 c=43", event_valid, event_repeat, event_code);
      end
      step(1);
      for (int m = 1; m <= 3; m++) begin
         n_cmp++;
         if (event_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL expiry_delay_m%0d: got v=%b want v=0", m, event_valid);
         end
         if (m == 3) key_held = 1'b0;
         step(1);
      end
      n_cmp++;
      if (debug_state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL expiry_end_idle: got state=%0d want 0", debug_state);
      end
   endtask

   task automatic test_reset_mid();
      key_code = 8'h41; key_held = 1'b1; event_ready = 1'b0;
      step(3);
      n_cmp++;
      if ({event_valid, event_code} !== {1'b1, 8'h41}) begin
         n_bad++;
         $display("FAIL pre_reset_emit: got v=%b c=%h want v=1 c=41", event_valid, event_code);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== 10'h000 || debug_state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL async_reset: got v=%b r=%b c=%h state=%0d want v=0 r=0 c=00 state=0", event_valid, event_repeat, event_code, debug_state);
      end
      step(1);
      rst = 1'b0;
      step(1);
      n_cmp++;
      if ({event_valid, event_repeat, event_code} !== {1'b1, 1'b0, 8'h41}) begin
         n_bad++;
         $display("FAIL post_reset_press: got v=%b r=%b c=%h want v=1 r=0 c=41", event_valid, event_repeat, event_code);
      end
      event_ready = 1'b1; key_held = 1'b0;
      step(1);
      n_cmp++;
      if (debug_state !== ST_IDLE || event_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle: got state=%0d v=%b want state=0 v=0", debug_state, event_valid);
      end
   endtask

   initial begin
      test_reset();
      test_repeat();
      test_stall();
      test_release();
      test_code_change();
      test_change_at_expiry();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
